alu_arbiter: RTL and testbench

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_arbiter.sv | 164 ++++++++++++++++
 tb/tb_alu_arbiter.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// Two-requester arbiter in front of a single shared ALU.
// One operation is in flight at a time: IDLE accepts, EXEC runs for EXEC_CYCLES cycles,
// RESP holds the result until the consumer takes it.
// Optional feature: define ALU_ARB_RR_EN for round-robin arbitration on contention;
// otherwise req0 has fixed priority.
module alu_arbiter #(
  parameter int unsigned EXEC_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [31:0] req0_op1,
  input  logic [31:0] req0_op2,
  input  logic [2:0]  req0_alu_op,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [31:0] req1_op1,
  input  logic [31:0] req1_op2,
  input  logic [2:0]  req1_alu_op,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic        resp_id,
  output logic [31:0] resp_data,
  output logic        busy
);

  localparam logic [3:0] CntInit = 4'(EXEC_CYCLES - 1);

  typedef enum logic [1:0] {StIdle, StExec, StResp} state_e;

  state_e      state_q, state_d;
  logic [31:0] op1_q, op1_d, op2_q, op2_d;
  logic [2:0]  alu_op_q, alu_op_d;
  logic        id_q, id_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] resp_data_q, resp_data_d;
  logic        resp_id_q, resp_id_d;

  logic        gnt_valid;
  logic        gnt_id;
  logic        accept;
  logic [31:0] alu_res;

  assign gnt_valid = req0_valid | req1_valid;
  assign accept    = (state_q == StIdle) && gnt_valid;

`ifdef ALU_ARB_RR_EN
  logic last_q, last_d;

  // On contention grant whoever was not granted last; otherwise the sole requester.
  always_comb begin
    if (req0_valid && req1_valid) begin
      gnt_id = ~last_q;
    end else begin
      gnt_id = ~req0_valid;
    end
    last_d = accept ? gnt_id : last_q;
  end

  // Last-grant register; resets to 1 so the first contention goes to req0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_q <= 1'b1;
    end else begin
      last_q <= last_d;
    end
  end
`else
  // Fixed priority: req0 wins whenever it is valid.
  always_comb begin
    gnt_id = ~req0_valid;
  end
`endif

  // Ready is combinational from the grant and forced low during reset.
  always_comb begin
    req0_ready = rst_n && accept && !gnt_id;
    req1_ready = rst_n && accept && gnt_id;
  end

  // Shared ALU, fed only from the captured operand registers.
  always_comb begin
    alu_res = 32'h0;
    case (alu_op_q)
      3'b000:  alu_res = op1_q + op2_q;
      3'b100:  alu_res = op1_q ^ op2_q;
      3'b110:  alu_res = op1_q | op2_q;
      3'b111:  alu_res = op1_q & op2_q;
      3'b001:  alu_res = op1_q << op2_q[4:0];
      3'b011:  alu_res = op1_q >> op2_q[4:0];
      3'b010:  alu_res = {32{op1_q < op2_q}};
      default: alu_res = 32'h0;
    endcase
  end

  // Next-state: capture on accept, count down in EXEC, hold result in RESP.
  always_comb begin
    state_d     = state_q;
    op1_d       = op1_q;
    op2_d       = op2_q;
    alu_op_d    = alu_op_q;
    id_d        = id_q;
    cnt_d       = cnt_q;
    resp_data_d = resp_data_q;
    resp_id_d   = resp_id_q;
    case (state_q)
      StIdle: begin
        if (gnt_valid) begin
          op1_d    = gnt_id ? req1_op1 : req0_op1;
          op2_d    = gnt_id ? req1_op2 : req0_op2;
          alu_op_d = gnt_id ? req1_alu_op : req0_alu_op;
          id_d     = gnt_id;
          cnt_d    = CntInit;
          state_d  = StExec;
        end
      end
      StExec: begin
        if (cnt_q == 4'd0) begin
          resp_data_d = alu_res;
          resp_id_d   = id_q;
          state_d     = StResp;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StResp: begin
        if (resp_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      op1_q       <= 32'h0;
      op2_q       <= 32'h0;
      alu_op_q    <= 3'b000;
      id_q        <= 1'b0;
      cnt_q       <= 4'd0;
      resp_data_q <= 32'h0;
      resp_id_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      op1_q       <= op1_d;
      op2_q       <= op2_d;
      alu_op_q    <= alu_op_d;
      id_q        <= id_d;
      cnt_q       <= cnt_d;
      resp_data_q <= resp_data_d;
      resp_id_q   <= resp_id_d;
    end
  end

  assign resp_valid = (state_q == StResp);
  assign resp_data  = resp_data_q;
  assign resp_id    = resp_id_q;
  assign busy       = (state_q != StIdle);

endmodule

// File: tb/tb_alu_arbiter.sv
// Bench for alu_arbiter: instance 0 uses EXEC_CYCLES=1, instance 1 uses EXEC_CYCLES=4.
// A transaction-level model predicts every output each cycle; directed tests add literals.
module tb_alu_arbiter;

  localparam int Ec0 = 1;
  localparam int Ec1 = 4;

  typedef struct {
    logic [31:0] d;
    logic        id;
    int          lat;
  } resp_t;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b1;
  logic [1:0]  r0v, r1v, rsp_rdy;
  logic [31:0] r0a[2], r0b[2], r1a[2], r1b[2];
  logic [2:0]  r0op[2], r1op[2];
  logic [1:0]  r0rdy, r1rdy, rvalid, rid, bsy;
  logic [31:0] rdata[2];

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  // Model state per instance
  bit          m_inflight[2];
  int          m_acc[2];
  logic [31:0] m_res[2], m_hold[2];
  logic        m_id[2], m_hold_id[2], m_last[2];
  bit          prev_rv[2];
  int          firstv[2];
  resp_t       log0[$], log1[$];
  int          g0[$], g1[$];

  alu_arbiter #(.EXEC_CYCLES(Ec0)) u_dut0 (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(r0v[0]), .req0_ready(r0rdy[0]), .req0_op1(r0a[0]), .req0_op2(r0b[0]),
    .req0_alu_op(r0op[0]),
    .req1_valid(r1v[0]), .req1_ready(r1rdy[0]), .req1_op1(r1a[0]), .req1_op2(r1b[0]),
    .req1_alu_op(r1op[0]),
    .resp_valid(rvalid[0]), .resp_ready(rsp_rdy[0]), .resp_id(rid[0]), .resp_data(rdata[0]),
    .busy(bsy[0])
  );

  alu_arbiter #(.EXEC_CYCLES(Ec1)) u_dut1 (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(r0v[1]), .req0_ready(r0rdy[1]), .req0_op1(r0a[1]), .req0_op2(r0b[1]),
    .req0_alu_op(r0op[1]),
    .req1_valid(r1v[1]), .req1_ready(r1rdy[1]), .req1_op1(r1a[1]), .req1_op2(r1b[1]),
    .req1_alu_op(r1op[1]),
    .resp_valid(rvalid[1]), .resp_ready(rsp_rdy[1]), .resp_id(rid[1]), .resp_data(rdata[1]),
    .busy(bsy[1])
  );

  always #5 clk = ~clk;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] alu_ref(logic [2:0] op, logic [31:0] a, logic [31:0] b);
    case (op)
      3'b000:  return a + b;
      3'b100:  return a ^ b;
      3'b110:  return a | b;
      3'b111:  return a & b;
      3'b001:  return a << b[4:0];
      3'b011:  return a >> b[4:0];
      3'b010:  return (a < b) ? 32'hFFFF_FFFF : 32'h0;
      default: return 32'h0;
    endcase
  endfunction

  function automatic int lat_of(int k);
    return (k == 0) ? Ec0 : Ec1;
  endfunction

  // Compare process: inputs are stable between posedge+1 and the next posedge, so the
  // values seen at negedge are what the coming edge will act on.
  always @(negedge clk) begin
    cyc++;
    for (int k = 0; k < 2; k++) begin
      if (!rst_n) begin
        check($sformatf("i%0d rst ready0", k), 32'(r0rdy[k]), 32'h0);
        check($sformatf("i%0d rst ready1", k), 32'(r1rdy[k]), 32'h0);
        check($sformatf("i%0d rst resp_valid", k), 32'(rvalid[k]), 32'h0);
        check($sformatf("i%0d rst busy", k), 32'(bsy[k]), 32'h0);
        check($sformatf("i%0d rst resp_data", k), rdata[k], 32'h0);
        check($sformatf("i%0d rst resp_id", k), 32'(rid[k]), 32'h0);
        m_inflight[k] = 1'b0;
        m_hold[k]     = 32'h0;
        m_hold_id[k]  = 1'b0;
        m_last[k]     = 1'b1;
        prev_rv[k]    = 1'b0;
      end else begin
        bit exp_rv, gv;
        int g;
        exp_rv = m_inflight[k] && (cyc >= m_acc[k] + lat_of(k) + 1);
        if (exp_rv) begin
          m_hold[k]    = m_res[k];
          m_hold_id[k] = m_id[k];
        end
        gv = !m_inflight[k] && (r0v[k] || r1v[k]);
        if (r0v[k] && r1v[k]) begin
`ifdef ALU_ARB_RR_EN
          g = (m_last[k] == 1'b0) ? 1 : 0;
`else
          g = 0;
`endif
        end else begin
          g = r0v[k] ? 0 : 1;
        end
        check($sformatf("i%0d ready0", k), 32'(r0rdy[k]), 32'(gv && g == 0));
        check($sformatf("i%0d ready1", k), 32'(r1rdy[k]), 32'(gv && g == 1));
        check($sformatf("i%0d busy", k), 32'(bsy[k]), 32'(m_inflight[k]));
        check($sformatf("i%0d resp_valid", k), 32'(rvalid[k]), 32'(exp_rv));
        check($sformatf("i%0d resp_data", k), rdata[k], m_hold[k]);
        check($sformatf("i%0d resp_id", k), 32'(rid[k]), 32'(m_hold_id[k]));
        if (rvalid[k] && !prev_rv[k]) firstv[k] = cyc;
        prev_rv[k] = rvalid[k];
        if (exp_rv && rsp_rdy[k]) begin
          resp_t e;
          e.d = rdata[k];
          e.id = rid[k];
          e.lat = firstv[k] - m_acc[k];
          if (k == 0) log0.push_back(e); else log1.push_back(e);
          m_inflight[k] = 1'b0;
        end else if (gv) begin
          m_inflight[k] = 1'b1;
          m_acc[k]      = cyc;
          m_id[k]       = g[0];
          m_last[k]     = g[0];
          m_res[k]      = (g == 0) ? alu_ref(r0op[k], r0a[k], r0b[k])
                                   : alu_ref(r1op[k], r1a[k], r1b[k]);
          if (k == 0) g0.push_back(g); else g1.push_back(g);
        end
      end
    end
  end

  function automatic int log_size(int k);
    return (k == 0) ? log0.size() : log1.size();
  endfunction

  // Present one operation and hold it until accepted; scramble operands afterwards.
  task automatic issue(int k, int r, logic [2:0] op, logic [31:0] a, logic [31:0] b);
    int n = 0;
    @(posedge clk); #1;
    if (r == 0) begin
      r0a[k] = a; r0b[k] = b; r0op[k] = op; r0v[k] = 1'b1;
    end else begin
      r1a[k] = a; r1b[k] = b; r1op[k] = op; r1v[k] = 1'b1;
    end
    @(negedge clk);
    while (!((r == 0) ? r0rdy[k] : r1rdy[k]) && n < 64) begin
      @(negedge clk);
      n++;
    end
    tests++;
    if (n >= 64) begin
      fails++;
      $display("FAIL accept timeout i%0d req%0d: got no ready expected ready", k, r);
    end
    @(posedge clk); #1;
    if (r == 0) begin
      r0v[k] = 1'b0; r0a[k] = 32'hDEAD_BEEF; r0b[k] = 32'h0BAD_F00D; r0op[k] = 3'b110;
    end else begin
      r1v[k] = 1'b0; r1a[k] = 32'hDEAD_BEEF; r1b[k] = 32'h0BAD_F00D; r1op[k] = 3'b110;
    end
  endtask

  task automatic wait_log(int k, int n);
    int t = 0;
    while (log_size(k) < n && t < 200) begin
      @(negedge clk);
      t++;
    end
    tests++;
    if (log_size(k) < n) begin
      fails++;
      $display("FAIL response timeout i%0d: got %0d responses expected %0d", k, log_size(k), n);
    end
  endtask

  task automatic pulse_reset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(negedge clk);
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic hand(int k, int idx, string name, logic [31:0] d, logic id, int lat);
    resp_t e;
    if (k == 0 ? idx >= log0.size() : idx >= log1.size()) begin
      tests++;
      fails++;
      $display("FAIL %s: got no response expected data %h", name, d);
      return;
    end
    e = (k == 0) ? log0[idx] : log1[idx];
    check({name, " data"}, e.d, d);
    check({name, " id"}, 32'(e.id), 32'(id));
    if (lat > 0) check({name, " latency"}, 32'(e.lat), 32'(lat));
  endtask

  initial begin
    int gb, lb;
    logic [1:0] exp_g;
    r0v = '0; r1v = '0; rsp_rdy = 2'b11;
    for (int k = 0; k < 2; k++) begin
      r0a[k] = '0; r0b[k] = '0; r1a[k] = '0; r1b[k] = '0; r0op[k] = '0; r1op[k] = '0;
    end
    #1 rst_n = 1'b0;
    r0v[0] = 1'b1;
    #2;
    check("ready0 low in reset", 32'(r0rdy[0]), 32'h0);
    r0v[0] = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    // Basic add, unsigned compare both ways, code 101, other ops
    issue(0, 0, 3'b000, 32'd5, 32'd7);
    wait_log(0, 1);
    hand(0, 0, "add 5+7", 32'h0000_000C, 1'b0, Ec0 + 1);
    issue(0, 1, 3'b010, 32'd3, 32'd9);
    wait_log(0, 2);
    hand(0, 1, "sltu 3<9", 32'hFFFF_FFFF, 1'b1, 0);
    issue(0, 1, 3'b010, 32'd9, 32'd3);
    wait_log(0, 3);
    hand(0, 2, "sltu 9<3", 32'h0000_0000, 1'b1, 0);
    issue(0, 0, 3'b101, 32'h1234_5678, 32'h9ABC_DEF0);
    wait_log(0, 4);
    hand(0, 3, "op101", 32'h0000_0000, 1'b0, 0);
    issue(0, 1, 3'b011, 32'h8000_0000, 32'd31);
    wait_log(0, 5);
    hand(0, 4, "shr", 32'h0000_0001, 1'b1, 0);
    issue(0, 0, 3'b000, 32'hFFFF_FFFF, 32'd2);
    wait_log(0, 6);
    hand(0, 5, "add wrap", 32'h0000_0001, 1'b0, 0);
    issue(0, 0, 3'b111, 32'hF0F0_FF00, 32'h0FF0_F0F0);
    wait_log(0, 7);
    hand(0, 6, "and", 32'h00F0_F000, 1'b0, 0);

    // A requester that withdraws while an op is in flight must not be served
    gb = g0.size();
    issue(0, 0, 3'b110, 32'h0000_00F0, 32'h0000_000F);
    r1v[0] = 1'b1; r1a[0] = 32'd1; r1b[0] = 32'd1;
    @(posedge clk); #1;
    r1v[0] = 1'b0;
    wait_log(0, 8);
    hand(0, 7, "or", 32'h0000_00FF, 1'b0, 0);
    repeat (3) @(negedge clk);
    check("withdrawn req1 not granted", 32'(g0.size()), 32'(gb + 1));

    // Contention after reset: four back-to-back grants
    pulse_reset();
    gb = g0.size();
    lb = log0.size();
    r0a[0] = 32'd1; r0b[0] = 32'd1; r0op[0] = 3'b000;
    r1a[0] = 32'd2; r1b[0] = 32'd2; r1op[0] = 3'b000;
    r0v[0] = 1'b1; r1v[0] = 1'b1;
    for (int t = 0; t < 100 && g0.size() < gb + 4; t++) @(negedge clk);
    @(posedge clk); #1;
    r0v[0] = 1'b0; r1v[0] = 1'b0;
    wait_log(0, lb + 4);
    for (int i = 0; i < 4; i++) begin
`ifdef ALU_ARB_RR_EN
      exp_g = 2'(i % 2);
`else
      exp_g = 2'd0;
`endif
      if (gb + i < g0.size()) check($sformatf("contention grant %0d", i), 32'(g0[gb + i]),
                                    32'(exp_g));
      else check($sformatf("contention grant %0d count", i), 32'(g0.size()), 32'(gb + 4));
      hand(0, lb + i, $sformatf("contention resp %0d", i),
           (exp_g == 2'd0) ? 32'd2 : 32'd4, exp_g[0], 0);
    end

    // EXEC_CYCLES=4 with a stalled consumer
    rsp_rdy[1] = 1'b0;
    issue(1, 0, 3'b001, 32'd1, 32'd4);
    for (int t = 0; t < 50 && !rvalid[1]; t++) @(negedge clk);
    repeat (3) @(posedge clk);
    #1 rsp_rdy[1] = 1'b1;
    wait_log(1, 1);
    hand(1, 0, "shl 1<<4", 32'h0000_0010, 1'b0, Ec1 + 1);

    // Reset in the middle of EXEC discards the operation
    issue(1, 0, 3'b000, 32'd3, 32'd3);
    @(posedge clk); #1;
    r0v[1] = 1'b1;
    rst_n = 1'b0;
    #1;
    check("busy drops at reset", 32'(bsy[1]), 32'h0);
    check("resp_valid low at reset", 32'(rvalid[1]), 32'h0);
    check("ready0 low while in reset", 32'(r0rdy[1]), 32'h0);
    @(negedge clk);
    @(posedge clk); #1;
    r0v[1] = 1'b0;
    rst_n = 1'b1;
    repeat (8) @(negedge clk);
    check("no response after reset", 32'(log1.size()), 32'd1);
    issue(1, 0, 3'b100, 32'h0000_00F0, 32'h0000_00FF);
    wait_log(1, 2);
    hand(1, 1, "xor after reset", 32'h0000_000F, 1'b0, Ec1 + 1);
    issue(1, 1, 3'b011, 32'hFFFF_0000, 32'd8);
    wait_log(1, 3);
    hand(1, 2, "shr i1", 32'h00FF_FF00, 1'b1, Ec1 + 1);

    repeat (3) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end

endmodule
